// File: rtl/ble_at_pkg.sv
// ble_at_pkg: opcodes, FSM states, prefix lengths, ASCII constants and hex encoding for the AT transmitter.
package ble_at_pkg;
    typedef enum logic [2:0] {
        AT_PING    = 3'd0,
        AT_RESET   = 3'd1,
        AT_CONNECT = 3'd2,
        AT_ADVI    = 3'd3,
        AT_ROLE    = 3'd4
    } at_op_t;
    typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_ARG, S_TERM, S_DONE} state_t;
    localparam logic [4:0] PFX_LEN_PING    = 5'd2;
    localparam logic [4:0] PFX_LEN_RESET   = 5'd8;
    localparam logic [4:0] PFX_LEN_CONNECT = 5'd6;
    localparam logic [4:0] PFX_LEN_ADVI    = 5'd7;
    localparam logic [4:0] PFX_LEN_ROLE    = 5'd7;
    localparam logic [4:0] MAC_CHARS       = 5'd12;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_UA   = 8'h41;
    localparam logic [7:0] ASCII_LA   = 8'h61;
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic upper);
        return (nibble < 4'd10) ? ASCII_ZERO + {4'd0, nibble}
                                : (upper ? ASCII_UA : ASCII_LA) + {4'd0, nibble} - 8'd10;
    endfunction
endpackage

// File: rtl/at_prefix_rom.sv
// at_prefix_rom: fixed ASCII prefix per opcode, its length and whether an operand follows.
module at_prefix_rom
    import ble_at_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic [4:0] idx_i,
    output logic [7:0] byte_o,
    output logic [4:0] len_o,
    output logic       has_arg_o
);
    logic [63:0] str;
    logic [63:0] str_sh;
    // Prefixes are left-aligned so character k is always the top byte after a shift by k bytes.
    assign str = (op_i == AT_PING)    ? {"AT", 48'h0}
               : (op_i == AT_RESET)   ? "AT+RESET"
               : (op_i == AT_CONNECT) ? {"AT+CON", 16'h0}
               : (op_i == AT_ADVI)    ? {"AT+ADVI", 8'h0}
               : (op_i == AT_ROLE)    ? {"AT+ROLE", 8'h0}
               : 64'h0;
    assign str_sh = str << {idx_i, 3'b000};
    assign byte_o = str_sh[63:56];
    assign len_o = (op_i == AT_PING)    ? PFX_LEN_PING
                 : (op_i == AT_RESET)   ? PFX_LEN_RESET
                 : (op_i == AT_CONNECT) ? PFX_LEN_CONNECT
                 : (op_i == AT_ADVI)    ? PFX_LEN_ADVI
                 : (op_i == AT_ROLE)    ? PFX_LEN_ROLE
                 : 5'd0;
    assign has_arg_o = (op_i == AT_CONNECT) || (op_i == AT_ADVI) || (op_i == AT_ROLE);
endmodule

// File: rtl/ble_at_transmitter.sv
// ble_at_transmitter: serialises one HM-10 AT command per request into a valid/ready UART byte stream.
module ble_at_transmitter
    import ble_at_pkg::*;
#(
    parameter bit APPEND_CRLF = 1'b0,
    parameter bit UPPER_HEX   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [47:0] cmd_mac,
    input  logic [3:0]  cmd_arg,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        err_bad_op
);
    state_t      state_q, state_d, post_state;
    logic [4:0]  idx_q, idx_d, plen, alen;
    logic [2:0]  op_q, op_sel;
    logic [47:0] mac_q, mac_sh;
    logic [3:0]  arg_q;
    logic [7:0]  byte_q, byte_d, rom_byte;
    logic        valid_q, valid_d, err_q;
    logic        load, accept, op_ok, has_arg, last;

    assign cmd_ready  = state_q == S_IDLE;
    assign busy       = !cmd_ready;
    assign done       = state_q == S_DONE;
    assign err_bad_op = err_q;
    assign tx_byte    = byte_q;
    assign tx_valid   = valid_q;
    assign op_ok      = cmd_op <= 3'd4;
    assign op_sel     = cmd_ready ? cmd_op : op_q;
    assign accept     = valid_q && tx_ready;
    assign alen       = (op_q == AT_CONNECT) ? MAC_CHARS : 5'd1;
    assign post_state = APPEND_CRLF ? S_TERM : S_DONE;

    at_prefix_rom u_rom (
        .op_i      (op_sel),
        .idx_i     (idx_d),
        .byte_o    (rom_byte),
        .len_o     (plen),
        .has_arg_o (has_arg)
    );

    // idx always points at the byte currently held in tx_byte; the next one is loaded on its handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                load    = cmd_valid && op_ok;
                state_d = load ? S_PREFIX : S_IDLE;
                idx_d   = 5'd0;
            end
            S_PREFIX: last = idx_q == plen - 5'd1;
            S_ARG:    last = idx_q == alen - 5'd1;
            S_TERM:   last = idx_q == 5'd1;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (state_q inside {S_PREFIX, S_ARG, S_TERM} && accept) begin
            load    = 1'b1;
            idx_d   = last ? 5'd0 : idx_q + 5'd1;
            state_d = !last                               ? state_q
                    : (state_q == S_PREFIX && has_arg)    ? S_ARG
                    : (state_q == S_TERM)                 ? S_DONE
                    : post_state;
        end
    end

    always_comb begin
        mac_sh  = mac_q << {idx_d, 2'b00};
        byte_d  = !load                ? byte_q
                : (state_d == S_PREFIX) ? rom_byte
                : (state_d == S_ARG)    ? nibble_to_ascii((op_q == AT_CONNECT) ? mac_sh[47:44] : arg_q, UPPER_HEX)
                : (state_d == S_TERM)   ? ((idx_d == 5'd0) ? ASCII_CR : ASCII_LF)
                : 8'h00;
        valid_d = load ? (state_d != S_DONE) : valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= 3'd0;
            mac_q   <= 48'h0;
            arg_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= cmd_ready && cmd_valid && !op_ok;
            if (cmd_ready && cmd_valid) begin
                op_q  <= cmd_op;
                mac_q <= cmd_mac;
                arg_q <= cmd_arg;
            end
        end
    end
endmodule

// File: tb/tb_ble_at_transmitter.sv
// tb_ble_at_transmitter: scoreboard bench driving a default instance and a CRLF/lowercase instance in lockstep.
module tb_ble_at_transmitter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [47:0] cmd_mac = 48'h0;
    logic [3:0]  cmd_arg = 4'h0;
    logic        tx_ready = 1'b0;
    logic        cmd_ready0, tx_valid0, busy0, done0, err0;
    logic        cmd_ready1, tx_valid1, busy1, done1, err1;
    logic [7:0]  tx_byte0, tx_byte1;

    always #5 clk = ~clk;

    ble_at_transmitter dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0), .cmd_op(cmd_op),
        .cmd_mac(cmd_mac), .cmd_arg(cmd_arg), .tx_byte(tx_byte0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready), .busy(busy0), .done(done0), .err_bad_op(err0)
    );
    ble_at_transmitter #(.APPEND_CRLF(1'b1), .UPPER_HEX(1'b0)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1), .cmd_op(cmd_op),
        .cmd_mac(cmd_mac), .cmd_arg(cmd_arg), .tx_byte(tx_byte1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready), .busy(busy1), .done(done1), .err_bad_op(err1)
    );

    typedef struct {
        logic [2:0]  op;
        logic [47:0] mac;
        logic [3:0]  arg;
        int          mode;
        int          len0;
        int          len1;
        bit          err;
    } vec_t;

    vec_t       vecs[12];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         n_vec = 0, n_err = 0;
    int         bytes0 = 0, bytes1 = 0, dones0 = 0, dones1 = 0, errs0 = 0, errs1 = 0;
    int         mode = 0, stall = 0;
    logic       pend0 = 1'b0, pend1 = 1'b0;
    logic [7:0] hold0 = 8'h0, hold1 = 8'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
        return (n < 4'd10) ? 8'h30 + 8'(n) : (up ? 8'h41 : 8'h61) + 8'(n) - 8'd10;
    endfunction

    task automatic push_exp(input logic [2:0] op, input logic [47:0] mac, input logic [3:0] arg);
        string s;
        case (op)
            3'd0: s = "AT";
            3'd1: s = "AT+RESET";
            3'd2: s = "AT+CON";
            3'd3: s = "AT+ADVI";
            3'd4: s = "AT+ROLE";
            default: s = "";
        endcase
        if (s.len() == 0) return;
        for (int i = 0; i < s.len(); i++) begin
            q0.push_back(s[i]);
            q1.push_back(s[i]);
        end
        if (op == 3'd2)
            for (int k = 0; k < 12; k++) begin
                q0.push_back(hexc(mac[47-4*k -: 4], 1'b1));
                q1.push_back(hexc(mac[47-4*k -: 4], 1'b0));
            end
        if (op == 3'd3 || op == 3'd4) begin
            q0.push_back(hexc(arg, 1'b1));
            q1.push_back(hexc(arg, 1'b0));
        end
        q1.push_back(8'h0D);
        q1.push_back(8'h0A);
    endtask

    task automatic mon();
        if (rst) begin
            pend0 = 1'b0;
            pend1 = 1'b0;
            return;
        end
        if (pend0) check("hold0", {tx_valid0, tx_byte0}, {1'b1, hold0});
        if (pend1) check("hold1", {tx_valid1, tx_byte1}, {1'b1, hold1});
        if (tx_valid0 && tx_ready) begin
            bytes0++;
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL extra0: got %0h required no byte", tx_byte0);
            end else check("byte0", tx_byte0, q0.pop_front());
        end
        if (tx_valid1 && tx_ready) begin
            bytes1++;
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL extra1: got %0h required no byte", tx_byte1);
            end else check("byte1", tx_byte1, q1.pop_front());
        end
        pend0 = tx_valid0 && !tx_ready;
        hold0 = tx_byte0;
        pend1 = tx_valid1 && !tx_ready;
        hold1 = tx_byte1;
        if (done0) dones0++;
        if (done1) dones1++;
        if (err0) errs0++;
        if (err1) errs1++;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready();
        if (mode == 0) tx_ready = 1'b1;
        else if (mode == 1) tx_ready = !tx_ready;
        else if (stall > 0) begin
            tx_ready = 1'b0;
            stall--;
        end else begin
            tx_ready = 1'b1;
            stall = $urandom_range(0, 5);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready0 && cmd_ready1 && q0.size() == 0 && q1.size() == 0) return;
            set_ready();
            tick();
        end
        n_vec++; n_err++;
        $display("FAIL %s: timeout, q0=%0d q1=%0d bytes still required", tag, q0.size(), q1.size());
        q0.delete();
        q1.delete();
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [47:0] mac, input logic [3:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mac   = mac;
        cmd_arg   = arg;
        push_exp(op, mac, arg);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_mac   = ~mac;
        cmd_arg   = ~arg;
    endtask

    task automatic run_vec(input vec_t v);
        int b0, b1, d0, d1, e0, e1;
        b0 = bytes0; b1 = bytes1; d0 = dones0; d1 = dones1; e0 = errs0; e1 = errs1;
        mode = v.mode;
        tx_ready = 1'b1;
        send_cmd(v.op, v.mac, v.arg);
        wait_idle("vec_idle");
        tick();
        tick();
        check("len0", bytes0 - b0, v.len0);
        check("len1", bytes1 - b1, v.len1);
        check("done0", dones0 - d0, v.err ? 0 : 1);
        check("done1", dones1 - d1, v.err ? 0 : 1);
        check("err0", errs0 - e0, v.err ? 1 : 0);
        check("err1", errs1 - e1, v.err ? 1 : 0);
        tx_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        int b;
        vecs[0]  = '{3'd0, 48'h0,            4'h0, 0, 2,  4,  1'b0};
        vecs[1]  = '{3'd1, 48'h0,            4'h0, 1, 8,  10, 1'b0};
        vecs[2]  = '{3'd2, 48'h0017EA9A1B2C, 4'h0, 0, 18, 20, 1'b0};
        vecs[3]  = '{3'd2, 48'h0017EA9A1B2C, 4'h0, 1, 18, 20, 1'b0};
        vecs[4]  = '{3'd2, 48'h0017EA9A1B2C, 4'h0, 2, 18, 20, 1'b0};
        vecs[5]  = '{3'd3, 48'h0,            4'hB, 0, 8,  10, 1'b0};
        vecs[6]  = '{3'd4, 48'h0,            4'h3, 2, 8,  10, 1'b0};
        vecs[7]  = '{3'd5, 48'h123456789ABC, 4'h1, 0, 0,  0,  1'b1};
        vecs[8]  = '{3'd7, 48'h0,            4'h0, 0, 0,  0,  1'b1};
        vecs[9]  = '{3'd2, 48'hFEDCBA987654, 4'h0, 2, 18, 20, 1'b0};
        vecs[10] = '{3'd3, 48'h0,            4'h0, 1, 8,  10, 1'b0};
        vecs[11] = '{3'd4, 48'h0,            4'hF, 0, 8,  10, 1'b0};

        repeat (3) tick();
        check("rst_hold", {tx_valid0, tx_byte0, done0, err0, busy0, cmd_ready0}, {1'b0, 8'h00, 4'b0001});
        rst = 1'b0;
        tx_ready = 1'b1;
        tick();
        check("rst_idle", {tx_valid0, tx_byte0, done0, err0, busy0, cmd_ready0}, {1'b0, 8'h00, 4'b0001});
        check("rst_idle1", {tx_valid1, busy1, cmd_ready1}, 3'b001);

        mode = 0;
        send_cmd(3'd0, 48'h0, 4'h0);
        check("ping_a", {tx_valid0, tx_byte0}, {1'b1, 8'h41});
        tick();
        check("ping_t", {tx_valid0, tx_byte0}, {1'b1, 8'h54});
        tick();
        check("ping_done", {tx_valid0, done0, cmd_ready0}, 3'b010);
        tick();
        check("ping_ready", {done0, cmd_ready0}, 2'b01);
        wait_idle("ping_idle");
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        send_cmd(3'd6, 48'h0, 4'h0);
        check("bad_pulse", {err0, tx_valid0, busy0}, 3'b100);
        tick();
        check("bad_clear", {err0, tx_valid0, busy0}, 3'b000);
        tick();
        check("bad_quiet", {err0, tx_valid0, busy0, cmd_ready0}, 4'b0001);

        tx_ready = 1'b1;
        b = bytes0;
        send_cmd(3'd2, 48'h0017EA9A1B2C, 4'h0);
        for (int i = 0; i < 50 && bytes0 - b < 5; i++) tick();
        check("rst_cnt", bytes0 - b, 5);
        rst = 1'b1;
        tick();
        check("rst_mid0", {tx_valid0, cmd_ready0, busy0, done0, tx_byte0}, {4'b0100, 8'h00});
        check("rst_mid1", {tx_valid1, cmd_ready1, busy1}, 3'b010);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        tick();
        run_vec(vecs[0]);

        check("left0", q0.size(), 0);
        check("left1", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ble_at_transmitter.md
# ble_at_transmitter

Transmit-side companion to the BLE connection monitor. It accepts a single command request (opcode plus operands) and serialises the matching HM-10-style ASCII AT command one byte at a time into the UART TX byte interface, using a valid/ready handshake. Hex operands, such as a 48-bit MAC, are converted to ASCII on the fly, which is the inverse of the monitor's MAC parser. It sits between the BLE setup/control logic and the UART transmitter.

## Interface
- `APPEND_CRLF`, default 0: when 1, every command is terminated with 0x0D 0x0A.
- `UPPER_HEX`, default 1: hex digits A–F are emitted as 0x41–0x46; when 0, as 0x61–0x66.

- `clk` in 1: single clock for the block.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block idle, can accept a command.
- `cmd_op` in 3: opcode of type `at_op_t`.
- `cmd_mac` in 48: MAC operand. Bits [47:40] are MAC byte 0 (`EIR_CENTRAL_MAC0`); bits [7:0] are MAC byte 5.
- `cmd_arg` in 4: single-nibble operand.
- `tx_byte` out 8: byte to UART TX.
- `tx_valid` out 1: `tx_byte` is valid.
- `tx_ready` in 1: UART TX accepts the byte this cycle.
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle pulse, command fully sent.
- `err_bad_op` out 1: one-cycle pulse, unsupported opcode.

## Operation
- Opcodes and emitted byte strings:
  - 0 `AT_PING`: "AT"
  - 1 `AT_RESET`: "AT+RESET"
  - 2 `AT_CONNECT`: "AT+CON" followed by 12 hex chars of `cmd_mac`, sent MSB nibble first
  - 3 `AT_ADVI`: "AT+ADVI" followed by 1 hex char of `cmd_arg`
  - 4 `AT_ROLE`: "AT+ROLE" followed by 1 hex char of `cmd_arg`
  - 5–7: invalid.
- Command lengths without CRLF are 2, 8, 18, 8 and 8 bytes respectively; `APPEND_CRLF` adds 2 to each.
- Command acceptance: a command is accepted on `cmd_valid && cmd_ready`. `cmd_op`, `cmd_mac` and `cmd_arg` are latched at that edge; later input changes are ignored.
- State machine states: `S_IDLE`, `S_PREFIX`, `S_ARG`, `S_TERM`, `S_DONE`.
  - `S_IDLE` → `S_PREFIX` on acceptance of a valid opcode.
  - `S_PREFIX` → `S_ARG` on acceptance of the last prefix byte, if the opcode has an operand.
  - `S_PREFIX` → `S_TERM` (if `APPEND_CRLF`) or `S_DONE` otherwise, for opcodes without an operand.
  - `S_ARG` → `S_TERM` or `S_DONE` after the last hex character.
  - `S_TERM` → `S_DONE` after LF is accepted.
  - `S_DONE` → `S_IDLE` unconditionally.
- Invalid opcode: the command is accepted, `err_bad_op` pulses the following cycle, no bytes are emitted, and the block stays in `S_IDLE`.
- Character index: a 5-bit counter. It is cleared on every state entry and increments on each accepted byte.
- Hex encoding: nibble 0–9 maps to 0x30–0x39; nibble 10–15 maps to 0x41–0x46 (or 0x61–0x66 when `UPPER_HEX`=0).
- Nibble selection: character k of the MAC (k = 0..11) is `cmd_mac_q[47-4k -: 4]`.
- `cmd_ready` = (state == `S_IDLE`). `busy` = !`cmd_ready`.

## Timing
- Reset values: `tx_valid`=0, `tx_byte`=0x00, `done`=0, `err_bad_op`=0, `busy`=0, `cmd_ready`=1, state `S_IDLE`, counters 0.
- Latency: `tx_valid` rises with the first byte ('A', 0x41) in the cycle after command acceptance.
- `tx_byte` and `tx_valid` are registered outputs.
- Handshake: a byte transfers on `tx_valid && tx_ready`. The next byte is loaded at that same edge, so sustained throughput is 1 byte per cycle.
- Once raised, `tx_valid` never drops and `tx_byte` never changes until that byte is accepted.
- `tx_ready` is ignored while `tx_valid`=0.
- After the last byte is accepted, `tx_valid`=0 and the state is `S_DONE` in the next cycle. `done`=1 in that cycle.
- `cmd_ready` returns to 1 in the following cycle, so the minimum gap between commands is 2 idle cycles on the TX side.
- Reset mid-command: at the first edge with `rst`=1, all outputs take their reset values. The partial command is abandoned and nothing is resumed.
- `cmd_valid` while busy: no effect and nothing is queued.

## Structure
- Package `ble_at_pkg` holds:
  - the `at_op_t` enum;
  - the state enum;
  - prefix-length constants;
  - ASCII constants (CR, LF, '0', 'A', 'a');
  - function `nibble_to_ascii(nibble, upper)`.
- Sub-module `at_prefix_rom`: combinational lookup (op, index) → prefix byte, plus prefix length and has-operand flag per opcode.
- The top level contains the FSM, the counter, the operand register and the output register.

## Test plan
- `AT_PING` with `tx_ready` held at 1 → `tx_byte` 0x41 then 0x54 on consecutive cycles, then `done` pulses once and `cmd_ready`=1 one cycle later.
- `AT_CONNECT` with `cmd_mac`=48'h0017EA9A1B2C, `UPPER_HEX`=1 → exactly the 18 bytes "AT+CON0017EA9A1B2C", and no byte is duplicated or dropped.
- Back-pressure: same CONNECT command with `tx_ready` alternating 0/1 and random 0–5 cycle stalls → each byte is held stable while `tx_valid`=1 and the sequence is unchanged.
- `cmd_op`=6 → `err_bad_op` is a single pulse, `tx_valid` stays 0, and `busy` stays 0.
- Reset after 5 bytes of CONNECT → `tx_valid`=0 and `cmd_ready`=1 in the cycle after the `rst` edge; a new PING then sends "AT" cleanly.
- `APPEND_CRLF`=1, `UPPER_HEX`=0, `AT_ADVI` with `cmd_arg`=4'hB → "AT+ADVIb" followed by 0x0D 0x0A, 10 bytes total.
